terminal_qsys_ddr_write_master: RTL

//  Avalon-MM burst write master that consumes the DDR base address driven by the base-address PIO.
//  It packs an incoming 32-bit Avalon-ST word stream into fixed-length bursts and writes one frame
//  of FRAME words to DDR, starting at the latched base address. Sits between the data source
//  (terminal datapath) and the DDR controller's Avalon-MM slave port in terminal_qsys.

---
 rtl/terminal_qsys_ddr_write_master.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/terminal_qsys_ddr_write_master.sv
// ---------------------------------------------------------------------------
// terminal_qsys_ddr_write_master
//
// Avalon-MM burst write master. Collects a 32-bit Avalon-ST word stream into
// an internal FIFO and writes one frame of frame_words words to DDR as
// fixed-length bursts (the last burst may be shorter), starting at the base
// address latched on start.
//
// Ports
//   clk, reset_n          system clock, asynchronous active-low reset
//   base_address          DDR byte base address, sampled on start
//   frame_words           words in the frame, sampled on start
//   start                 1-cycle pulse that begins a frame (ignored unless idle)
//   busy                  frame in progress
//   done                  1-cycle pulse after the last beat of the frame
//   st_data/valid/ready   Avalon-ST word input
//   avm_address           burst start byte address
//   avm_write             write request
//   avm_writedata         write data (FIFO head)
//   avm_burstcount        beats in the current burst
//   avm_waitrequest       slave stall
// ---------------------------------------------------------------------------
module terminal_qsys_ddr_write_master #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 32,
    parameter int BURST_LEN  = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int LEN_W      = 24
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic [ADDR_W-1:0]              base_address,
    input  logic [LEN_W-1:0]               frame_words,
    input  logic                           start,
    output logic                           busy,
    output logic                           done,
    input  logic [DATA_W-1:0]              st_data,
    input  logic                           st_valid,
    output logic                           st_ready,
    output logic [ADDR_W-1:0]              avm_address,
    output logic                           avm_write,
    output logic [DATA_W-1:0]              avm_writedata,
    output logic [$clog2(BURST_LEN):0]     avm_burstcount,
    input  logic                           avm_waitrequest
);

    localparam int BC_W    = $clog2(BURST_LEN) + 1;
    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int BYTE_SH = $clog2(DATA_W / 8);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_BURST,
        S_DONE
    } state_t;

    state_t            state;
    state_t            state_d;

    logic [ADDR_W-1:0] addr_q;
    logic [LEN_W-1:0]  remaining;
    logic [LEN_W-1:0]  to_accept;
    logic [BC_W-1:0]   bc_q;
    logic [BC_W-1:0]   beat_q;
    logic [BC_W-1:0]   burst_n;

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  fifo_count;

    logic              fifo_full;
    logic              in_burst;
    logic              push;
    logic              pop;
    logic              last_beat;
    logic              load_frame;
    logic              launch;

    // Size of the next burst: a full burst, or whatever is left of the frame.
    always_comb begin
        if (remaining >= LEN_W'(BURST_LEN)) begin
            burst_n = BC_W'(BURST_LEN);
        end else begin
            burst_n = remaining[BC_W-1:0];
        end
    end

    assign busy      = (state == S_WAIT) || (state == S_BURST);
    assign done      = (state == S_DONE);
    assign in_burst  = (state == S_BURST);
    assign fifo_full = (fifo_count == CNT_W'(FIFO_DEPTH));

    // Words beyond the frame length are never taken, so the FIFO is empty
    // again once the last burst has drained.
    assign st_ready  = busy && !fifo_full && (to_accept != '0);
    assign push      = st_valid && st_ready;
    assign pop       = in_burst && !avm_waitrequest;
    assign last_beat = pop && (beat_q == bc_q - BC_W'(1));

    // A burst is only launched once all of its beats sit in the FIFO, so
    // avm_write can stay high for the whole burst without bubbles. The
    // address/burstcount/data outputs come from registers that only move on
    // an accepted beat, so they hold while the slave stalls.
    assign avm_write      = in_burst;
    assign avm_address    = in_burst ? addr_q : '0;
    assign avm_burstcount = in_burst ? bc_q : '0;
    assign avm_writedata  = in_burst ? mem[rd_ptr] : '0;

    // ---- FSM state register ----
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_d;
        end
    end

    // ---- FSM next state / control strobes ----
    always_comb begin
        state_d    = state;
        load_frame = 1'b0;
        launch     = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    load_frame = 1'b1;
                    state_d    = (frame_words == '0) ? S_DONE : S_WAIT;
                end
            end
            S_WAIT: begin
                if (fifo_count >= CNT_W'(burst_n)) begin
                    launch  = 1'b1;
                    state_d = S_BURST;
                end
            end
            S_BURST: begin
                if (last_beat) begin
                    state_d = (remaining == LEN_W'(bc_q)) ? S_DONE : S_WAIT;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ---- frame / burst bookkeeping ----
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr_q    <= '0;
            remaining <= '0;
            to_accept <= '0;
            bc_q      <= '0;
            beat_q    <= '0;
        end else begin
            if (load_frame) begin
                addr_q    <= base_address;
                remaining <= frame_words;
                to_accept <= frame_words;
            end else if (push) begin
                to_accept <= to_accept - LEN_W'(1);
            end

            if (launch) begin
                bc_q   <= burst_n;
                beat_q <= '0;
            end else if (pop) begin
                beat_q <= beat_q + BC_W'(1);
                if (last_beat) begin
                    remaining <= remaining - LEN_W'(bc_q);
                    // Byte address advances by the burst size; wraps mod 2^ADDR_W.
                    addr_q    <= addr_q + (ADDR_W'(bc_q) << BYTE_SH);
                end
            end
        end
    end

    // ---- word FIFO: pointers and occupancy ----
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CNT_W'(1);
                2'b01:   fifo_count <= fifo_count - CNT_W'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // ---- word FIFO: storage (data only, not reset) ----
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= st_data;
        end
    end

endmodule
